// File: rtl/arbiter_rr_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// Latency: none, wires only.
// Backpressure: none; requesters hold req until served, gnt is the only return path.
// Signals: req (N), gnt (N one-hot), gnt_valid, gnt_id; lock exists only when ARB_LOCK_EN is defined.
interface arbiter_rr_if #(
    parameter int N = 4
) ();
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
`ifdef ARB_LOCK_EN
    logic          lock;

    modport master (output req, output lock, input gnt, input gnt_valid, input gnt_id);
    modport slave  (input req, input lock, output gnt, output gnt_valid, output gnt_id);
`else
    modport master (output req, input gnt, input gnt_valid, input gnt_id);
    modport slave  (input req, output gnt, output gnt_valid, output gnt_id);
`endif
endinterface

// File: rtl/arbiter_rr.sv
// N-way round-robin arbiter with registered one-hot grant and bounded hold time.
// Latency: one edge from req change to gnt change; handoff between owners has no idle cycle.
// Backpressure: requesters wait with req high; an owner is forced off after MAX_HOLD cycles if others wait.
// Ports: clock, reset_n (async active-low), bus (arbiter_rr_if.slave: req in; gnt, gnt_valid, gnt_id out).
// Optional: define ARB_LOCK_EN to add bus.lock, which lets the owner suspend the hold limit.
module arbiter_rr #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    arbiter_rr_if.slave  bus
);
    localparam int IW          = (N > 1) ? $clog2(N) : 1;
    localparam int HW          = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LAST_I);
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] LAST_ID   = IW'(N - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          vld_q, vld_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [N-1:0]  owner_oh;
    logic [N-1:0]  others;
    logic          owner_req;
    logic          lock_act;
    logic          expire;
    logic          rel;
    logic [IW-1:0] after_owner;

    // First set bit of v, searching start, start+1, ... modulo N.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] v, input logic [IW-1:0] start);
        logic [2*N-1:0] rot;
        int             off;
        int             sum;
        rot = {v, v} >> start;
        off = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        sum = int'(start) + off;
        if (sum >= N) sum = sum - N;
        return IW'(sum);
    endfunction

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        owner_oh    = ONE << id_q;
        others      = bus.req & ~owner_oh;
        owner_req   = bus.req[id_q];
        after_owner = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
`ifdef ARB_LOCK_EN
        lock_act    = bus.lock & owner_req;
`else
        lock_act    = 1'b0;
`endif
        // Forced release only when someone else is actually waiting.
        expire      = (MAX_HOLD != 0) && !lock_act && (hold_q == HOLD_LAST) && (|others);
        rel         = !owner_req || expire;

        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (|bus.req) begin
                    id_d    = pick(bus.req, ptr_q);
                    gnt_d   = ONE << id_d;
                    state_d = BUSY;
                end else begin
                    id_d  = '0;
                    gnt_d = '0;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_d  = after_owner;
                    hold_d = '0;
                    if (|others) begin
                        // Owner is masked out so an expired owner re-competes next time.
                        id_d  = pick(others, after_owner);
                        gnt_d = ONE << id_d;
                    end else begin
                        id_d    = '0;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (lock_act || (MAX_HOLD == 0)) begin
                    hold_d = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = '0;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
        vld_d = |gnt_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = vld_q;
    assign bus.gnt_id    = id_q;
endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr (N=4, MAX_HOLD=8) with hand-computed grant sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// The lock scenario runs only when ARB_LOCK_EN is defined.
module tb_arbiter_rr;
    localparam int N = 4;
    localparam int M = 8;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;
    int   tally [N];

    arbiter_rr_if #(.N(N)) bus ();

    arbiter_rr #(.N(N), .MAX_HOLD(M)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] g, input logic [1:0] id);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, ".vld"}, 32'(bus.gnt_valid), 32'(g != 4'b0));
        check({tag, ".id"}, 32'(bus.gnt_id), 32'(id));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = 4'b0000;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        bus.req = 4'b1111;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        #1;
        // 1. reset holds everything off even with all requests high
        for (int c = 0; c < 5; c++) begin
            step();
            expect_gnt("rst", 4'b0000, 2'd0);
        end
        bus.req = 4'b0100;
        reset_n = 1'b1;
        step();
        expect_gnt("first", 4'b0100, 2'd2);

        // 2. back-to-back handoff from 0 to 2
        do_reset();
        bus.req = 4'b0001;
        step();
        expect_gnt("ho.own0", 4'b0001, 2'd0);
        bus.req = 4'b0101;
        step();
        expect_gnt("ho.keep0", 4'b0001, 2'd0);
        bus.req = 4'b0100;
        step();
        expect_gnt("ho.to2", 4'b0100, 2'd2);
        bus.req = 4'b0000;
        step();
        expect_gnt("ho.idle", 4'b0000, 2'd0);

        // 3. fairness: 8 cycles each in order 0,1,2,3
        do_reset();
        for (int i = 0; i < N; i++) tally[i] = 0;
        bus.req = 4'b1111;
        for (int c = 0; c < 64; c++) begin
            int e;
            logic [3:0] eg;
            step();
            e  = (c / M) % N;
            eg = 4'b0001 << e;
            check("rr.gnt", 32'(bus.gnt), 32'(eg));
            check("rr.id", 32'(bus.gnt_id), 32'(e));
            for (int i = 0; i < N; i++) if (bus.gnt[i]) tally[i]++;
        end
        for (int i = 0; i < N; i++) check("rr.tally", 32'(tally[i]), 32'd16);

        // 4. lone requester keeps grant past the hold limit
        do_reset();
        bus.req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            step();
            check("lone.gnt", 32'(bus.gnt), 32'h2);
        end
        bus.req = 4'b1010;
        step();
        expect_gnt("lone.to3", 4'b1000, 2'd3);

        // 5. asynchronous reset in the middle of a grant
        do_reset();
        bus.req = 4'b1000;
        step();
        expect_gnt("ar.own3", 4'b1000, 2'd3);
        #2;
        reset_n = 1'b0;
        #1;
        expect_gnt("ar.clear", 4'b0000, 2'd0);
        bus.req = 4'b1001;
        step();
        reset_n = 1'b1;
        step();
        expect_gnt("ar.ptr0", 4'b0001, 2'd0);

`ifdef ARB_LOCK_EN
        // 6. lock suspends the hold limit; limit resumes from zero after unlock
        do_reset();
        bus.req  = 4'b0010;
        bus.lock = 1'b1;
        step();
        expect_gnt("lk.own1", 4'b0010, 2'd1);
        bus.req = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            step();
            check("lk.hold", 32'(bus.gnt), 32'h2);
        end
        bus.lock = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            check("lk.tail", 32'(bus.gnt), 32'h2);
        end
        step();
        expect_gnt("lk.to2", 4'b0100, 2'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
